// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request/response port and external SRAM pin bundle for sram_ctrl
interface sram_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
);
  localparam int NB = DATA_W / 8;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [NB-1:0]     req_be;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_out;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_in;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [NB-1:0]     sram_be_n;
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, sram_dq_in,
    output req_ready, resp_valid, resp_rdata, sram_addr, sram_dq_out, sram_dq_oe,
           sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, sram_dq_in,
    input  req_ready, resp_valid, resp_rdata, sram_addr, sram_dq_out, sram_dq_oe,
           sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready request port to asynchronous SRAM with programmable wait states; define SRAM_CTRL_STATS_EN for read/write response counters
module sram_ctrl #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 16,
  parameter int WAIT_RD = 1,
  parameter int WAIT_WR = 1
) (
  input  logic        clk,
  input  logic        resetn,
  sram_ctrl_if.slave  bus
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt
`endif
);
  localparam int NB = DATA_W / 8;
  typedef enum logic [2:0] {IDLE, RD, TURN, WR_SETUP, WR_PULSE, WR_HOLD, ACK} state_t;
  state_t            r_state, w_nxt;
  logic [3:0]        r_cnt, w_cnt;
  logic [NB-1:0]     r_be, w_be, r_be_n;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq, r_rdata, w_mask;
  logic              r_ce_n, r_oe_n, r_we_n, r_dq_oe, r_resp_valid;
  logic              w_acc, w_rd_s, w_wr_s, w_resp;
  assign bus.req_ready   = resetn && r_state == IDLE;
  assign w_acc           = bus.req_valid && bus.req_ready;
  assign w_be            = w_acc ? bus.req_be : r_be;
  assign w_rd_s          = w_nxt == RD;
  assign w_wr_s          = w_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD};
  assign w_resp          = w_nxt inside {TURN, WR_HOLD, ACK};
  assign bus.sram_addr   = r_addr;
  assign bus.sram_dq_out = r_dq;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_ce_n   = r_ce_n;
  assign bus.sram_oe_n   = r_oe_n;
  assign bus.sram_we_n   = r_we_n;
  assign bus.sram_be_n   = r_be_n;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_rdata  = r_rdata;
  // lane mask of the latched byte enables, applied to captured read data
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NB; i++) w_mask[8*i +: 8] = {8{r_be[i]}};
  end
  // next state and wait counter; counter loads on entry and counts down to 0
  always_comb begin
    w_nxt = r_state;
    w_cnt = r_cnt;
    case (r_state)
      IDLE: if (w_acc) begin
        w_nxt = bus.req_be == '0 ? ACK : bus.req_we ? WR_SETUP : RD;
        w_cnt = 4'(WAIT_RD);
      end
      RD: begin
        w_nxt = r_cnt == 4'd0 ? TURN : RD;
        w_cnt = r_cnt - 4'd1;
      end
      WR_SETUP: begin
        w_nxt = WR_PULSE;
        w_cnt = 4'(WAIT_WR);
      end
      WR_PULSE: begin
        w_nxt = r_cnt == 4'd0 ? WR_HOLD : WR_PULSE;
        w_cnt = r_cnt - 4'd1;
      end
      default: w_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
    end
  // pins and response registered from the next state so strobes align with it
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_addr       <= '0;
      r_dq         <= '0;
      r_be         <= '0;
      r_be_n       <= '1;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_dq_oe      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (w_acc) begin
        r_addr <= bus.req_addr;
        r_be   <= bus.req_be;
        if (bus.req_we) r_dq <= bus.req_wdata;
      end
      r_ce_n       <= !(w_rd_s || w_wr_s);
      r_oe_n       <= !w_rd_s;
      r_we_n       <= w_nxt != WR_PULSE;
      r_dq_oe      <= w_wr_s;
      r_be_n       <= (w_rd_s || w_wr_s) ? ~w_be : '1;
      r_resp_valid <= w_resp;
      r_rdata      <= (r_state == RD && w_nxt == TURN) ? (bus.sram_dq_in & w_mask) :
                      w_resp ? '0 : r_rdata;
    end
`ifdef SRAM_CTRL_STATS_EN
  logic [31:0] r_stat_rd, r_stat_wr;
  assign stat_rd_cnt = r_stat_rd;
  assign stat_wr_cnt = r_stat_wr;
  // response counters, bumped together with the resp_valid they count
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_stat_rd <= '0;
      r_stat_wr <= '0;
    end else begin
      if (w_nxt == TURN || (w_nxt == ACK && !bus.req_we)) r_stat_rd <= r_stat_rd + 32'd1;
      if (w_nxt == WR_HOLD || (w_nxt == ACK && bus.req_we)) r_stat_wr <= r_stat_wr + 32'd1;
    end
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized and directed bench for sram_ctrl against an SRAM pin model and a word-level reference memory
module tb_sram_ctrl;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 16;
  localparam int WAIT_RD = 1;
  localparam int WAIT_WR = 1;
  localparam int NB      = DATA_W / 8;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef SRAM_CTRL_STATS_EN
  logic [31:0] stat_rd_cnt, stat_wr_cnt;
`endif
  sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_RD(WAIT_RD), .WAIT_WR(WAIT_WR)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus.slave)
`ifdef SRAM_CTRL_STATS_EN
    ,
    .stat_rd_cnt(stat_rd_cnt),
    .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [DATA_W-1:0] sram_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_mem  [logic [ADDR_W-1:0]];

  always @(posedge clk) cyc++;

  // pin-level asynchronous SRAM plus protocol watchdogs
  logic              prev_oe_n = 1'b1, prev_we_n = 1'b1, prev_rv = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_dq = '0;
  logic [DATA_W-1:0] mv;
  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      if (bus.sram_dq_oe && (!bus.sram_oe_n || !prev_oe_n)) begin
        failures++;
        $display("FAIL bus_turnaround dq_oe=%b oe_n=%b prev_oe_n=%b at cyc %0d", bus.sram_dq_oe, bus.sram_oe_n, prev_oe_n, cyc);
      end
      checks++;
      if (bus.resp_valid && prev_rv) begin
        failures++;
        $display("FAIL resp_valid_consecutive got two high cycles at cyc %0d", cyc);
      end
      if (!bus.sram_we_n && !prev_we_n) begin
        checks++;
        if (bus.sram_addr !== prev_addr || bus.sram_dq_out !== prev_dq) begin
          failures++;
          $display("FAIL we_low_stability addr=%h/%h dq=%h/%h", bus.sram_addr, prev_addr, bus.sram_dq_out, prev_dq);
        end
      end
      if (!bus.sram_ce_n && !bus.sram_we_n) begin
        mv = sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr] : '0;
        for (int i = 0; i < NB; i++) if (!bus.sram_be_n[i]) mv[8*i +: 8] = bus.sram_dq_out[8*i +: 8];
        sram_mem[bus.sram_addr] = mv;
      end
    end
    if (!bus.sram_ce_n && !bus.sram_oe_n) begin
      mv = sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr] : '0;
      for (int i = 0; i < NB; i++) if (bus.sram_be_n[i]) mv[8*i +: 8] = 8'hEE;
      bus.sram_dq_in = mv;
    end else bus.sram_dq_in = {NB{8'h5A}};
    prev_oe_n = resetn ? bus.sram_oe_n : 1'b1;
    prev_we_n = resetn ? bus.sram_we_n : 1'b1;
    prev_rv   = resetn ? bus.resp_valid : 1'b0;
    prev_addr = bus.sram_addr;
    prev_dq   = bus.sram_dq_out;
  end

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a, input logic [NB-1:0] be);
    logic [DATA_W-1:0] v;
    v = ref_mem.exists(a) ? ref_mem[a] : '0;
    for (int i = 0; i < NB; i++) if (!be[i]) v[8*i +: 8] = 8'h00;
    return v;
  endfunction

  // one request: waits for ready, records pin activity until the response
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [NB-1:0] be, output logic [DATA_W-1:0] rd, output int lat,
                        output int t0, output int n_oe, output int n_we, output int n_ce,
                        output int n_dqoe, output logic [NB-1:0] bn);
    int n;
    logic [DATA_W-1:0] v;
    bus.req_we = we; bus.req_addr = a; bus.req_wdata = d; bus.req_be = be; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!bus.req_ready) begin
      failures++;
      $display("FAIL req_ready_timeout ready=%b after %0d cycles", bus.req_ready, n);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    t0 = cyc; lat = 0; rd = '0; n_oe = 0; n_we = 0; n_ce = 0; n_dqoe = 0; bn = '1;
    for (int k = 0; k < 64; k++) begin
      if (!bus.sram_oe_n) n_oe++;
      if (!bus.sram_we_n) n_we++;
      if (bus.sram_dq_oe) n_dqoe++;
      if (!bus.sram_ce_n) begin n_ce++; bn = bus.sram_be_n; end
      if (bus.resp_valid) begin lat = k + 1; rd = bus.resp_rdata; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (lat == 0) begin
      failures++;
      $display("FAIL resp_timeout no resp_valid within 64 cycles, required one");
    end else if (we) begin
      exp_wr++;
      v = ref_mem.exists(a) ? ref_mem[a] : '0;
      for (int i = 0; i < NB; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
      ref_mem[a] = v;
    end else exp_rd++;
  endtask

  logic [DATA_W-1:0] rd, ex;
  int lat, t0, t1, n_oe, n_we, n_ce, n_dqoe;
  logic [NB-1:0] bn;

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    checks++;
    if ({bus.req_ready, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n, bus.sram_dq_oe,
         bus.sram_addr, bus.sram_dq_out, bus.resp_valid, bus.resp_rdata} !==
        {1'b0, 3'b111, {NB{1'b1}}, 1'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, 1'b0, {DATA_W{1'b0}}}) begin
      failures++;
      $display("FAIL reset_state ready=%b ce_n=%b oe_n=%b we_n=%b be_n=%b dq_oe=%b addr=%h dq=%h rv=%b rdata=%h",
               bus.req_ready, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n, bus.sram_dq_oe,
               bus.sram_addr, bus.sram_dq_out, bus.resp_valid, bus.resp_rdata);
    end
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %b need 1", bus.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_req(1'b1, ADDR_W'('h12345), DATA_W'('hA5C3), 2'b11, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (lat !== WAIT_WR + 3 || n_we !== WAIT_WR + 1 || n_ce !== WAIT_WR + 3 || n_dqoe !== WAIT_WR + 3 || n_oe !== 0 || rd !== '0) begin
      failures++;
      $display("FAIL write_timing lat=%0d we=%0d ce=%0d dqoe=%0d oe=%0d rd=%h need %0d/%0d/%0d/%0d/0/0",
               lat, n_we, n_ce, n_dqoe, n_oe, rd, WAIT_WR + 3, WAIT_WR + 1, WAIT_WR + 3, WAIT_WR + 3);
    end
    ex = exp_read(ADDR_W'('h12345), 2'b11);
    do_req(1'b0, ADDR_W'('h12345), '0, 2'b11, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (rd !== ex || lat !== WAIT_RD + 2 || n_oe !== WAIT_RD + 1 || n_dqoe !== 0 || n_we !== 0) begin
      failures++;
      $display("FAIL read_back rd=%h lat=%0d oe=%0d dqoe=%0d we=%0d need %h/%0d/%0d/0/0", rd, lat, n_oe, n_dqoe, n_we, ex, WAIT_RD + 2, WAIT_RD + 1);
    end
  endtask

  task automatic test_byte_lanes();
    do_req(1'b1, ADDR_W'('h12345), DATA_W'('h00FF), 2'b01, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (bn !== 2'b10) begin
      failures++;
      $display("FAIL write_be_n got %b need 10", bn);
    end
    ex = exp_read(ADDR_W'('h12345), 2'b11);
    do_req(1'b0, ADDR_W'('h12345), '0, 2'b11, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (rd !== ex) begin
      failures++;
      $display("FAIL lane_merge got %h need %h", rd, ex);
    end
    ex = exp_read(ADDR_W'('h12345), 2'b10);
    do_req(1'b0, ADDR_W'('h12345), '0, 2'b10, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (rd !== ex || bn !== 2'b01) begin
      failures++;
      $display("FAIL upper_lane_read rd=%h be_n=%b need %h/01", rd, bn, ex);
    end
  endtask

  task automatic test_be_zero();
    do_req(1'b1, ADDR_W'('h12345), DATA_W'('hFFFF), 2'b00, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (lat !== 1 || n_ce !== 0 || n_we !== 0 || rd !== '0) begin
      failures++;
      $display("FAIL be_zero_write lat=%0d ce=%0d we=%0d rd=%h need 1/0/0/0", lat, n_ce, n_we, rd);
    end
    do_req(1'b0, ADDR_W'('h12345), '0, 2'b00, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (lat !== 1 || n_ce !== 0 || n_oe !== 0 || rd !== '0) begin
      failures++;
      $display("FAIL be_zero_read lat=%0d ce=%0d oe=%0d rd=%h need 1/0/0/0", lat, n_ce, n_oe, rd);
    end
    ex = exp_read(ADDR_W'('h12345), 2'b11);
    do_req(1'b0, ADDR_W'('h12345), '0, 2'b11, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (rd !== ex) begin
      failures++;
      $display("FAIL be_zero_unchanged got %h need %h", rd, ex);
    end
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, ADDR_W'(3), '0, 2'b11, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    do_req(1'b0, ADDR_W'(4), '0, 2'b11, rd, lat, t1, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (t1 - t0 !== WAIT_RD + 3) begin
      failures++;
      $display("FAIL read_spacing got %0d need %0d", t1 - t0, WAIT_RD + 3);
    end
    do_req(1'b1, ADDR_W'(5), DATA_W'($urandom), 2'b11, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    do_req(1'b1, ADDR_W'(6), DATA_W'($urandom), 2'b11, rd, lat, t1, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (t1 - t0 !== WAIT_WR + 4) begin
      failures++;
      $display("FAIL write_spacing got %0d need %0d", t1 - t0, WAIT_WR + 4);
    end
  endtask

  task automatic test_random();
    logic we;
    logic [ADDR_W-1:0] a;
    logic [NB-1:0] be;
    int el;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom);
      a  = ADDR_W'($urandom_range(0, 7)) + ADDR_W'('h40000);
      be = NB'($urandom_range(0, (1 << NB) - 1));
      ex = we ? '0 : exp_read(a, be);
      el = be == '0 ? 1 : we ? WAIT_WR + 3 : WAIT_RD + 2;
      do_req(we, a, DATA_W'($urandom), be, rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
      checks++;
      if (rd !== ex || lat !== el || (be != '0 && bn !== ~be) || n_we !== ((be != '0 && we) ? WAIT_WR + 1 : 0)) begin
        failures++;
        $display("FAIL random_%0d we=%b addr=%h be=%b rd=%h lat=%0d be_n=%b nwe=%0d need rd=%h lat=%0d", n, we, a, be, rd, lat, bn, n_we, ex, el);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bus.req_we = 1'b1; bus.req_addr = ADDR_W'('h7FFFF); bus.req_wdata = DATA_W'('h1234); bus.req_be = '1; bus.req_valid = 1'b1;
    for (int n = 0; n < 50 && !bus.req_ready; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.sram_we_n !== 1'b0) begin
      failures++;
      $display("FAIL pulse_entry we_n=%b need 0", bus.sram_we_n);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.sram_we_n, bus.sram_ce_n, bus.sram_oe_n, bus.sram_dq_oe, bus.resp_valid, bus.req_ready, bus.sram_addr, bus.sram_dq_out} !==
        {3'b111, 3'b000, {ADDR_W{1'b0}}, {DATA_W{1'b0}}}) begin
      failures++;
      $display("FAIL reset_abort we_n=%b ce_n=%b oe_n=%b dq_oe=%b rv=%b ready=%b addr=%h dq=%h",
               bus.sram_we_n, bus.sram_ce_n, bus.sram_oe_n, bus.sram_dq_oe, bus.resp_valid, bus.req_ready, bus.sram_addr, bus.sram_dq_out);
    end
    exp_rd = 0;
    exp_wr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_abort got %b need 1", bus.req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL no_resp_after_abort got %b need 0", bus.resp_valid);
      end
    end
  endtask

  task automatic test_stats();
`ifdef SRAM_CTRL_STATS_EN
    for (int n = 0; n < 3; n++) do_req(1'b1, ADDR_W'(n), DATA_W'($urandom), NB'(n), rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    for (int n = 0; n < 2; n++) do_req(1'b0, ADDR_W'(n), '0, NB'(n + 1), rd, lat, t0, n_oe, n_we, n_ce, n_dqoe, bn);
    checks++;
    if (stat_rd_cnt !== 32'(exp_rd) || stat_wr_cnt !== 32'(exp_wr)) begin
      failures++;
      $display("FAIL stats rd=%0d wr=%0d need %0d/%0d", stat_rd_cnt, stat_wr_cnt, exp_rd, exp_wr);
    end
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
    bus.sram_dq_in = '0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_be_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    test_stats();
    test_random();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
